// File: rtl/mem_init_pkg.sv
// Shared types and defaults for the memory burst initiator.
// Defaults match the dual-port memory this block drives.
package mem_init_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StFinish = 2'd2
    } state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
    localparam int unsigned DEFAULT_MEM_DEPTH  = 49152;
    localparam int unsigned DEFAULT_TIMEOUT    = 255;

endpackage

// File: rtl/mem_watchdog.sv
// Wait counter for a pending beat. o_tc is high during the TIMEOUT-th
// consecutive waiting cycle, so the owner can abort at that edge.
module mem_watchdog
    import mem_init_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastWait = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LastWait)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == LastWait);

endmodule

// File: rtl/mem_burst_initiator.sv
// Burst initiator for one memory port: issues single-beat transactions,
// writes an incrementing pattern and checks read data against it.
module mem_burst_initiator
    import mem_init_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned MEM_DEPTH  = DEFAULT_MEM_DEPTH,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    output logic                  mem_valid,
    output logic                  mem_op,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] err_cnt,
    output logic                  timeout,
    output logic                  bad_cmd
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_e                r_state;
    logic                  r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_err;
    logic                  r_timeout;
    logic                  r_bad;

    logic w_tc;
    logic w_wd_clr;
    logic w_wd_en;
    logic w_addr_bad;
    logic w_rd_mismatch;

    assign w_wd_clr      = (r_state != StIssue) || mem_ready;
    assign w_wd_en       = (r_state == StIssue) && !mem_ready;
    assign w_addr_bad    = (32'(cmd_addr) >= MEM_DEPTH);
    assign w_rd_mismatch = (r_op == OP_READ) && (mem_rd_data != r_data);

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_wd_clr),
        .i_en  (w_wd_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_op      <= OP_READ;
            r_addr    <= '0;
            r_data    <= '0;
            r_len     <= '0;
            r_err     <= '0;
            r_timeout <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (cmd_valid) begin
                        r_op      <= cmd_op;
                        r_addr    <= cmd_addr;
                        r_data    <= cmd_seed;
                        r_len     <= cmd_len;
                        r_err     <= '0;
                        r_timeout <= 1'b0;
                        r_bad     <= w_addr_bad;
                        if (w_addr_bad || (cmd_len == '0)) begin
                            r_state <= StFinish;
                        end else begin
                            r_state <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (mem_ready) begin
                        r_addr <= (r_addr == LastAddr) ? '0 : r_addr + 1'b1;
                        r_data <= r_data + 1'b1;
                        r_len  <= r_len - 1'b1;
                        if (w_rd_mismatch && (r_err != '1)) begin
                            r_err <= r_err + 1'b1;
                        end
                        if (r_len == ADDR_WIDTH'(1)) begin
                            r_state <= StFinish;
                        end
                    end else if (w_tc) begin
                        // Remaining beats are dropped on abort.
                        r_timeout <= 1'b1;
                        r_state   <= StFinish;
                    end
                end
                StFinish: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == StIdle);
    assign mem_valid   = (r_state == StIssue);
    assign busy        = (r_state != StIdle);
    assign done        = (r_state == StFinish);
    assign mem_op      = r_op;
    assign mem_addr    = r_addr;
    assign mem_wr_data = (r_op == OP_WRITE) ? r_data : '0;
    assign err_cnt     = r_err;
    assign timeout     = r_timeout;
    assign bad_cmd     = r_bad;

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Scoreboard bench for mem_burst_initiator with a behavioural memory
// model and a configurable mem_ready responder.
module tb_mem_burst_initiator;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 49152;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          op;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic [DW-1:0] cmd_seed = '0;
    logic          mem_valid;
    logic          mem_op;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic          mem_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [AW-1:0] err_cnt;
    logic          timeout;
    logic          bad_cmd;

    logic [DW-1:0] mem_model [DEPTH];
    beat_t         sb_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            ready_mode = 0;  // 0: responsive, 1: stuck low
    int            stall_left = 0;
    int            beat_idx = 0;
    int            valid_cycles = 0;

    always #5 clk = ~clk;

    mem_burst_initiator dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_seed    (cmd_seed),
        .mem_valid   (mem_valid),
        .mem_op      (mem_op),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .done        (done),
        .err_cnt     (err_cnt),
        .timeout     (timeout),
        .bad_cmd     (bad_cmd)
    );

    assign mem_rd_data = (int'(mem_addr) < DEPTH) ? mem_model[mem_addr] : '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Responder: stall beat 1 for stall_left cycles, or hold ready low.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            mem_ready = 1'b0;
        end else if (stall_left > 0 && mem_valid && beat_idx == 1) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = 1'b1;
        end
    end

    // Every presented beat must match the queue head and stay stable until accepted.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && mem_valid) begin
            valid_cycles++;
            if (sb_q.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                e = sb_q[0];
                check("beat_addr", 64'(mem_addr), 64'(e.addr));
                check("beat_op", 64'(mem_op), 64'(e.op));
                check("beat_wdata", 64'(mem_wr_data), 64'(e.data));
                if (mem_ready) begin
                    if (mem_op) mem_model[mem_addr] = mem_wr_data;
                    void'(sb_q.pop_front());
                    beat_idx++;
                end
            end
        end
    end

    task automatic push_beats(input logic op, input logic [AW-1:0] addr,
                              input logic [AW-1:0] len, input logic [DW-1:0] seed);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = addr;
        d = seed;
        for (int i = 0; i < int'(len); i++) begin
            sb_q.push_back('{addr: a, op: op, data: (op ? d : '0)});
            a = (int'(a) == DEPTH - 1) ? '0 : a + 1'b1;
            d = d + 1'b1;
        end
    endtask

    task automatic issue(input logic op, input logic [AW-1:0] addr,
                         input logic [AW-1:0] len, input logic [DW-1:0] seed,
                         input int stalls, input int mode, input logic bad);
        int waitc;
        waitc = 0;
        while (!cmd_ready && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        check("cmd_ready_before", 64'(cmd_ready), 64'd1);
        if (!bad) push_beats(op, addr, len, seed);
        ready_mode   = mode;
        stall_left   = stalls;
        beat_idx     = 0;
        valid_cycles = 0;
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_addr     = addr;
        cmd_len      = len;
        cmd_seed     = seed;
        @(posedge clk);
        #1;
        cmd_valid    = 1'b0;
    endtask

    task automatic run_cmd(input logic op, input logic [AW-1:0] addr,
                           input logic [AW-1:0] len, input logic [DW-1:0] seed,
                           input int stalls, input int mode, input int exp_lat,
                           input int exp_vcyc, input logic [AW-1:0] exp_err,
                           input logic exp_to, input logic exp_bad);
        int lat;
        issue(op, addr, len, seed, stalls, mode, exp_bad);
        lat = 1;
        while (!done && lat < 600) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_latency", 64'(lat), 64'(exp_lat));
        check("busy_at_done", 64'(busy), 64'd1);
        check("valid_at_done", 64'(mem_valid), 64'd0);
        check("err_cnt", 64'(err_cnt), 64'(exp_err));
        check("timeout", 64'(timeout), 64'(exp_to));
        check("bad_cmd", 64'(bad_cmd), 64'(exp_bad));
        check("valid_cycles", 64'(valid_cycles), 64'(exp_vcyc));
        check("beats_left", 64'(sb_q.size()), (mode == 1) ? 64'(len) : 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("ready_after", 64'(cmd_ready), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("err_held", 64'(err_cnt), 64'(exp_err));
        ready_mode = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_op", 64'(mem_op), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wr_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_bad_cmd", 64'(bad_cmd), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // op, addr, len, seed, stalls, mode, lat, vcyc, err, to, bad
        run_cmd(1'b1, 16'h0010, 16'd4, 32'hA5A5_0000, 0, 0, 5, 4, 16'd0, 1'b0, 1'b0);
        run_cmd(1'b0, 16'h0010, 16'd4, 32'hA5A5_0000, 0, 0, 5, 4, 16'd0, 1'b0, 1'b0);
        mem_model[16'h0012] = mem_model[16'h0012] ^ 32'h0000_0100;
        run_cmd(1'b0, 16'h0010, 16'd4, 32'hA5A5_0000, 0, 0, 5, 4, 16'd1, 1'b0, 1'b0);
        run_cmd(1'b1, 16'd49150, 16'd4, 32'hFFFF_FFFF, 0, 0, 5, 4, 16'd0, 1'b0, 1'b0);
        check("wrap_word0", 64'(mem_model[0]), 64'h0000_0001);
        check("wrap_word1", 64'(mem_model[1]), 64'h0000_0002);
        run_cmd(1'b0, 16'd49150, 16'd4, 32'hFFFF_FFFF, 0, 0, 5, 4, 16'd0, 1'b0, 1'b0);
        run_cmd(1'b0, 16'd49150, 16'd4, 32'h0000_0000, 0, 0, 5, 4, 16'd4, 1'b0, 1'b0);
        run_cmd(1'b1, 16'h0040, 16'd4, 32'h0000_0100, 3, 0, 8, 7, 16'd0, 1'b0, 1'b0);
        run_cmd(1'b0, 16'h0040, 16'd4, 32'h0000_0100, 0, 1, 256, 255, 16'd0, 1'b1, 1'b0);
        run_cmd(1'b1, 16'h0080, 16'd0, 32'h0000_0000, 0, 0, 1, 0, 16'd0, 1'b0, 1'b0);
        run_cmd(1'b1, 16'd49152, 16'd4, 32'h0000_0000, 0, 0, 1, 0, 16'd0, 1'b0, 1'b1);
        run_cmd(1'b1, 16'h0090, 16'd1, 32'h5555_AAAA, 0, 0, 2, 1, 16'd0, 1'b0, 1'b0);
        check("len1_word", 64'(mem_model[16'h0090]), 64'h5555_AAAA);

        // Reset while beat 2 of a burst is presented.
        issue(1'b1, 16'h0200, 16'd8, 32'h1234_0000, 0, 0, 1'b0);
        k = 0;
        while (beat_idx < 2 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("reached_beat2", 64'(beat_idx), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", 64'(mem_valid), 64'd0);
        check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("mid_rst_no_done", 64'(done), 64'd0);
            @(posedge clk);
            #1;
        end
        sb_q.delete();
        run_cmd(1'b0, 16'h0200, 16'd2, 32'h1234_0000, 0, 0, 3, 2, 16'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
